shader_rr_arbiter: RTL and testbench
====================================

SHADER_RR_ARBITER -- requirements
Module: shader_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of upstream requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32: payload width per requester in bits.
REQ-003 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port valid_us  input  NUM_IN: per-requester valid.
REQ-006 SHALL have port data_us  input  NUM_IN x WIDTH (packed 2-D): per-requester payload.
REQ-007 SHALL have port stall_us  output  NUM_IN: per-requester stall; a transfer occurs when valid_us[i] & ~stall_us[i].
REQ-008 SHALL have port valid_ds  output  1: registered output valid.
REQ-009 SHALL have port data_ds  output  WIDTH: registered output payload.
REQ-010 SHALL have port grant_id  output  $clog2(NUM_IN): index of the requester whose payload sits in data_ds.
REQ-011 SHALL have port stall_ds  input  1: downstream stall; a transfer occurs when valid_ds & ~stall_ds.

Function
REQ-012 SHALL hold one output register (valid_ds, data_ds, grant_id); latency from accepted upstream transfer to valid_ds is exactly 1 cycle.
REQ-013 SHALL compute accept = ~valid_ds | ~stall_ds; no upstream transfer occurs in a cycle where accept is 0.
REQ-014 SHALL, when accept is 1 and any valid_us is set, select exactly one winner w and load data_us[w], grant_id=w, valid_ds=1 at the next edge.
REQ-015 SHALL, when accept is 1 and no valid_us is set, load valid_ds=0 at the next edge; data_ds and grant_id keep their values.
REQ-016 SHALL drive stall_us[i] = valid_us[i] & ~(accept & (i==w)); stall_us[i] is 0 when valid_us[i] is 0.
REQ-017 SHALL keep valid_ds, data_ds, grant_id stable while valid_ds & stall_ds.
REQ-018 SHALL, in round-robin mode, search from index (last+1) mod NUM_IN upward with wrap-around, where last is the most recently granted index; last updates only on a granted transfer.
REQ-019 SHALL leave last unchanged in cycles with no grant (idle or accept=0).
REQ-020 SHALL permit a single continuously-valid requester to win every accepting cycle (full throughput, no bubbles).
REQ-021 SHALL permit a stall_ds-to-stall_us combinational path; no combinational path from valid_us to valid_ds.
REQ-022 SHALL never drop or duplicate a payload: each upstream transfer produces exactly one downstream transfer.

Reset
REQ-023 SHALL, while rst is 1 at a clock edge, set valid_ds=0, data_ds=0, grant_id=0, last=NUM_IN-1 (so index 0 has first priority after reset).
REQ-024 SHALL discard any payload held in the output register when rst asserts mid-operation; stall_us is all-ones-masked-by-valid (no transfer) during the reset cycle.
REQ-025 SHALL ignore stall_ds and valid_us while rst is 1.

Configuration
REQ-026 SHALL compile round-robin selection (REQ-018/019) when macro SHADER_ARB_FIXED_PRIO_EN is undefined.
REQ-027 SHALL, when SHADER_ARB_FIXED_PRIO_EN is defined, select the lowest-index valid requester every accepting cycle; last register is not instantiated; all other requirements unchanged.

Verification
REQ-028 SHALL verify: after reset, valid_us=4'b1111 held, stall_ds=0 -> grant_id sequence 0,1,2,3,0,1 on consecutive cycles starting 1 cycle later, valid_ds continuously 1.
REQ-029 SHALL verify: valid_us=4'b0100 held, data_us[2] incrementing each transfer -> data_ds increments every cycle, no bubbles, stall_us[2]=0 throughout.
REQ-030 SHALL verify: output holding payload 0xA5A5A5A5 from port 1, stall_ds=1 for 5 cycles with valid_us=4'b1111 -> data_ds=0xA5A5A5A5, grant_id=1 stable, stall_us=4'b1111 for all 5 cycles; on release next grant is port 2.
REQ-031 SHALL verify: valid_us=4'b1001, port 3 granted, then valid_us=4'b1001 -> next grant port 0 (wrap-around), then port 3.
REQ-032 SHALL verify: rst asserted while valid_ds=1 and stall_ds=1 -> next cycle valid_ds=0, data_ds=0, grant_id=0; first post-reset grant with all valid is port 0.
REQ-033 SHALL verify with SHADER_ARB_FIXED_PRIO_EN defined: valid_us=4'b1111 held, stall_ds=0 -> grant_id=0 every cycle, stall_us=4'b1110.

Source files
------------

// File: rtl/shader_rr_arbiter.sv
// Round-robin arbiter merging NUM_IN valid/stall upstream ports into one registered downstream port.
// Define SHADER_ARB_FIXED_PRIO_EN to build a fixed lowest-index-first priority arbiter instead.
module shader_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_IN-1:0]              valid_us,
  input  logic [NUM_IN-1:0][WIDTH-1:0]   data_us,
  output logic [NUM_IN-1:0]              stall_us,
  output logic                           valid_ds,
  output logic [WIDTH-1:0]               data_ds,
  output logic [$clog2(NUM_IN)-1:0]      grant_id,
  input  logic                           stall_ds
);

  localparam int IDX_W = $clog2(NUM_IN);

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [IDX_W-1:0]  gid_q, gid_d;
  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  win;
  logic              found;
  logic              accept;
  logic              grant;

`ifdef SHADER_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [IDX_W-1:0]  last_q, last_d;

  // Search begins one past the most recent winner, wrapping at NUM_IN (which need not be a power of two).
  assign start_idx = (last_q == IDX_W'(NUM_IN - 1)) ? '0 : last_q + 1'b1;
`endif

  assign accept = ~valid_q | ~stall_ds;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = IDX_W'((int'(start_idx) + k) % NUM_IN);
      if (!found && valid_us[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Reset blocks every upstream transfer regardless of accept.
  assign grant = accept & found & ~rst;

  always_comb begin
    stall_us = valid_us;
    if (grant) begin
      stall_us[win] = 1'b0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    gid_d   = gid_q;
`ifndef SHADER_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    if (accept) begin
      valid_d = found;
    end
    if (grant) begin
      data_d = data_us[win];
      gid_d  = win;
`ifndef SHADER_ARB_FIXED_PRIO_EN
      last_d = win;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
`ifndef SHADER_ARB_FIXED_PRIO_EN
      last_q  <= IDX_W'(NUM_IN - 1);
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
`ifndef SHADER_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign valid_ds = valid_q;
  assign data_ds  = data_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_shader_rr_arbiter.sv
// Directed self-checking bench for shader_rr_arbiter (NUM_IN=4, WIDTH=32).
module tb_shader_rr_arbiter;

  localparam int NUM_IN = 4;
  localparam int WIDTH  = 32;

  logic                         clk = 1'b0;
  logic                         rst;
  logic [NUM_IN-1:0]            valid_us;
  logic [NUM_IN-1:0][WIDTH-1:0] data_us;
  logic [NUM_IN-1:0]            stall_us;
  logic                         valid_ds;
  logic [WIDTH-1:0]             data_ds;
  logic [1:0]                   grant_id;
  logic                         stall_ds;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shader_rr_arbiter #(.NUM_IN(NUM_IN), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_us (valid_us),
    .data_us  (data_us),
    .stall_us (stall_us),
    .valid_ds (valid_ds),
    .data_ds  (data_ds),
    .grant_id (grant_id),
    .stall_ds (stall_ds)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where registered outputs are settled.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_s;

    rst      = 1'b1;
    valid_us = '0;
    stall_ds = 1'b0;
    for (int i = 0; i < NUM_IN; i++) data_us[i] = 32'h100 + i;
    tick;
    tick;
    chk("rst_valid", {31'd0, valid_ds}, 32'd0);
    chk("rst_data",  data_ds, 32'd0);
    chk("rst_gid",   {30'd0, grant_id}, 32'd0);
    chk("rst_stall", {28'd0, stall_us}, 32'd0);
    rst = 1'b0;

`ifdef SHADER_ARB_FIXED_PRIO_EN
    valid_us = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1 chk("fp_stall", {28'd0, stall_us}, 32'h0000_000E);
      tick;
      chk("fp_gid",   {30'd0, grant_id}, 32'd0);
      chk("fp_valid", {31'd0, valid_ds}, 32'd1);
      chk("fp_data",  data_ds, 32'h100);
    end
`else
    // All four requesting: rotation 0,1,2,3,0,1 with no bubbles.
    valid_us = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      exp_s = 4'b1111;
      exp_s[c % 4] = 1'b0;
      #1 chk("rr_stall", {28'd0, stall_us}, {28'd0, exp_s});
      tick;
      chk("rr_gid",   {30'd0, grant_id}, 32'(c % 4));
      chk("rr_valid", {31'd0, valid_ds}, 32'd1);
      chk("rr_data",  data_ds, 32'h100 + 32'(c % 4));
    end

    // Single requester streams at full rate.
    valid_us = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      data_us[2] = 32'h200 + c;
      #1 chk("solo_stall", {28'd0, stall_us}, 32'd0);
      tick;
      chk("solo_data",  data_ds, 32'h200 + c);
      chk("solo_gid",   {30'd0, grant_id}, 32'd2);
      chk("solo_valid", {31'd0, valid_ds}, 32'd1);
    end

    // Load 0xA5A5A5A5 from port 1, then hold it under downstream stall.
    valid_us   = 4'b0010;
    data_us[1] = 32'hA5A5_A5A5;
    #1 chk("a5_stall", {28'd0, stall_us}, 32'd0);
    tick;
    chk("a5_data", data_ds, 32'hA5A5_A5A5);
    chk("a5_gid",  {30'd0, grant_id}, 32'd1);
    data_us[0] = 32'h1000;
    data_us[2] = 32'h3000;
    data_us[3] = 32'h4000;
    valid_us   = 4'b1111;
    stall_ds   = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("hold_stall", {28'd0, stall_us}, 32'h0000_000F);
      tick;
      chk("hold_data",  data_ds, 32'hA5A5_A5A5);
      chk("hold_gid",   {30'd0, grant_id}, 32'd1);
      chk("hold_valid", {31'd0, valid_ds}, 32'd1);
    end
    stall_ds = 1'b0;
    #1 chk("rel_stall", {28'd0, stall_us}, 32'h0000_000B);
    tick;
    chk("rel_gid",  {30'd0, grant_id}, 32'd2);
    chk("rel_data", data_ds, 32'h3000);

    // Ports 0 and 3: 3 first, then wrap to 0, then back to 3.
    valid_us = 4'b1001;
    #1 chk("wrap1_stall", {28'd0, stall_us}, 32'h0000_0001);
    tick;
    chk("wrap1_gid", {30'd0, grant_id}, 32'd3);
    #1 chk("wrap2_stall", {28'd0, stall_us}, 32'h0000_0008);
    tick;
    chk("wrap2_gid",  {30'd0, grant_id}, 32'd0);
    chk("wrap2_data", data_ds, 32'h1000);
    #1 chk("wrap3_stall", {28'd0, stall_us}, 32'h0000_0001);
    tick;
    chk("wrap3_gid", {30'd0, grant_id}, 32'd3);

    // Idle cycle: valid drops, payload and id kept, pointer unchanged.
    valid_us = 4'b0000;
    #1 chk("idle_stall", {28'd0, stall_us}, 32'd0);
    tick;
    chk("idle_valid", {31'd0, valid_ds}, 32'd0);
    chk("idle_gid",   {30'd0, grant_id}, 32'd3);
    chk("idle_data",  data_ds, 32'h4000);
    valid_us = 4'b1111;
    #1 chk("post_idle_stall", {28'd0, stall_us}, 32'h0000_000E);
    tick;
    chk("post_idle_gid", {30'd0, grant_id}, 32'd0);
    chk("post_idle_valid", {31'd0, valid_ds}, 32'd1);
`endif

    // Reset while output is held under stall: payload discarded, priority back to port 0.
    stall_ds = 1'b1;
    tick;
    chk("pre_rst_valid", {31'd0, valid_ds}, 32'd1);
    rst = 1'b1;
    #1 chk("rst1_stall", {28'd0, stall_us}, 32'h0000_000F);
    tick;
    chk("mid_rst_valid", {31'd0, valid_ds}, 32'd0);
    chk("mid_rst_data",  data_ds, 32'd0);
    chk("mid_rst_gid",   {30'd0, grant_id}, 32'd0);
    stall_ds = 1'b0;
    #1 chk("rst2_stall", {28'd0, stall_us}, 32'h0000_000F);
    tick;
    chk("rst2_valid", {31'd0, valid_ds}, 32'd0);
    rst = 1'b0;
    #1 chk("post_rst_stall", {28'd0, stall_us}, 32'h0000_000E);
    tick;
    chk("post_rst_gid",   {30'd0, grant_id}, 32'd0);
    chk("post_rst_valid", {31'd0, valid_ds}, 32'd1);
    chk("post_rst_data",  data_ds, data_us[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
